// File: rtl/mem_seq.sv
// mem_seq: byte-serial big-endian load/store sequencer in front of an 8-bit
// simple dual-port RAM with a registered (1-cycle) read port.
module mem_seq #(
    parameter int addr_width = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic [addr_width-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic [addr_width-1:0] ram_waddr,
    output logic [7:0]            ram_din,
    output logic                  ram_we,
    output logic [addr_width-1:0] ram_raddr,
    input  logic [7:0]            ram_dout
);
    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;
    state_t state;
    logic [addr_width-1:0] addr;
    logic [31:0] wdata, acc, acc_next;
    logic [2:0] n, k, req_n;

    // Byte idx of an n-byte big-endian value: idx 0 is the most significant.
    function automatic logic [7:0] byte_of(input logic [31:0] d, input logic [2:0] cnt, input logic [2:0] idx);
        logic [31:0] s;
        s = d >> {cnt - idx - 3'd1, 3'b000};
        return s[7:0];
    endfunction

    assign req_n = req_size == 2'd0 ? 3'd1 : req_size == 2'd1 ? 3'd2 : 3'd4;
    assign req_ready = state == IDLE;
    assign acc_next = {acc[23:0], ram_dout};

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            ram_we    <= 1'b0;
            ram_waddr <= '0;
            ram_din   <= '0;
            ram_raddr <= '0;
            addr      <= '0;
            wdata     <= '0;
            acc       <= '0;
            n         <= '0;
            k         <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    addr  <= req_addr;
                    wdata <= req_wdata;
                    n     <= req_n;
                    k     <= 3'd1;
                    acc   <= '0;
                    // Byte 0 is presented at acceptance so the RAM sees it in cycle T+1.
                    if (req_write) begin
                        state     <= WRITE;
                        ram_we    <= 1'b1;
                        ram_waddr <= req_addr;
                        ram_din   <= byte_of(req_wdata, req_n, 3'd0);
                    end else begin
                        state     <= READ;
                        ram_raddr <= req_addr;
                    end
                end
                WRITE: if (k == n) begin
                    ram_we    <= 1'b0;
                    rsp_valid <= 1'b1;
                    state     <= DONE;
                end else begin
                    ram_waddr <= addr + addr_width'(k);
                    ram_din   <= byte_of(wdata, n, k);
                    k         <= k + 3'd1;
                end
                READ: begin
                    // ram_dout carries byte k-2 while k counts addresses issued.
                    if (k >= 3'd2) acc <= acc_next;
                    if (k < n) ram_raddr <= addr + addr_width'(k);
                    k <= k + 3'd1;
                    if (k == n + 3'd1) begin
                        rsp_rdata <= acc_next;
                        rsp_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule
